// File: rtl/smem_result_writer.sv
// Result-line sink for the SMEM output stage: grants the producer, buffers lines in
// a FWFT FIFO with margin-based stall, streams to the host and closes with a trailer.
module smem_result_writer #(
  parameter int FIFO_DEPTH   = 16,
  parameter int STALL_MARGIN = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_request,
  output logic         in_permit,
  input  logic [511:0] in_data,
  input  logic         in_valid,
  input  logic         in_finish,
  output logic         stall,
  output logic [511:0] host_data,
  output logic         host_valid,
  input  logic         host_ready,
  output logic         host_last,
  output logic [31:0]  line_count,
  output logic         overflow,
  output logic         done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] STALL_TH = (AW+1)'(FIFO_DEPTH - STALL_MARGIN);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_DRAIN, S_TRAILER, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [511:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count, w_count_nxt;
  logic            r_permit, r_stall, r_overflow;
  logic [31:0]     r_line_count;
  logic            w_stream, w_empty, w_pop, w_push_req, w_push, w_start;

  assign w_stream   = (r_state == S_GRANT) || (r_state == S_DRAIN);
  assign w_empty    = (r_count == '0);
  assign w_pop      = w_stream && !w_empty && host_ready;
  assign w_push_req = w_stream && in_valid;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push     = w_push_req && ((r_count < DEPTH_C) || w_pop);
  assign w_start    = (r_state == S_IDLE) && in_request;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (in_request) w_next = S_GRANT;
      S_GRANT:   if (in_finish) w_next = S_DRAIN;
      S_DRAIN:   if (w_empty && !in_valid) w_next = S_TRAILER;
      S_TRAILER: if (host_ready) w_next = S_DONE;
      S_DONE:    if (!in_request) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    host_valid = 1'b0;
    host_last  = 1'b0;
    host_data  = '0;
    if (w_stream && !w_empty) begin
      host_valid = 1'b1;
      host_data  = r_mem[r_rd_ptr];
    end else if (r_state == S_TRAILER) begin
      host_valid       = 1'b1;
      host_last        = 1'b1;
      host_data[31:0]  = r_line_count;
      host_data[63:32] = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_permit     <= 1'b0;
      r_stall      <= 1'b1;
      r_overflow   <= 1'b0;
      r_line_count <= '0;
    end else begin
      r_state  <= w_next;
      r_count  <= w_count_nxt;
      r_permit <= (w_next == S_GRANT);
      r_stall  <= (w_count_nxt >= STALL_TH) ||
                  (w_next inside {S_IDLE, S_TRAILER, S_DONE});
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_start) begin
        r_line_count <= '0;
        r_overflow   <= 1'b0;
      end else begin
        if (w_push && (r_line_count != 32'hFFFF_FFFF)) r_line_count <= r_line_count + 32'd1;
        if (w_push_req && !w_push) r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  assign in_permit  = r_permit;
  assign stall      = r_stall;
  assign line_count = r_line_count;
  assign overflow   = r_overflow;
  assign done       = (r_state == S_DONE);
endmodule

// File: tb/tb_smem_result_writer.sv
// Randomized bench for smem_result_writer; a queue-based model predicts FIFO
// acceptance, host beat order, counts, stall and the trailer line.
module tb_smem_result_writer;
  logic         clk = 1'b0;
  logic         reset;
  logic         in_request, in_valid, in_finish, host_ready;
  logic [511:0] in_data;
  logic         in_permit, stall, host_valid, host_last, overflow, done;
  logic [511:0] host_data;
  logic [31:0]  line_count;

  smem_result_writer #(.FIFO_DEPTH(16), .STALL_MARGIN(4)) dut (
    .clk(clk), .reset(reset), .in_request(in_request), .in_permit(in_permit),
    .in_data(in_data), .in_valid(in_valid), .in_finish(in_finish), .stall(stall),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .host_last(host_last), .line_count(line_count), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [511:0] mq[$];
  logic [31:0]  m_cnt;
  bit           m_ovf, m_active, got_trailer;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: capture the handshake seen before the edge, then update the model.
  task automatic cyc();
    logic hs, lst, push;
    logic [511:0] d;
    hs   = host_valid && host_ready;
    lst  = host_last;
    d    = host_data;
    push = in_valid && m_active;
    @(posedge clk); #1;
    if (hs) begin
      if (lst) begin
        chk("trailer", d, {448'd0, 32'hFFFF_FFFF, m_cnt});
        got_trailer = 1'b1;
      end else if (mq.size() == 0) begin
        chk("spurious_beat", 512'd1, 512'd0);
      end else begin
        chk("host_data", d, mq.pop_front());
      end
    end
    if (push) begin
      if (mq.size() < 16) begin
        mq.push_back(in_data);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_permit"}, 512'(in_permit), 512'd0);
    chk({tag, "_stall"}, 512'(stall), 512'd1);
    chk({tag, "_hvalid"}, 512'(host_valid), 512'd0);
    chk({tag, "_hlast"}, 512'(host_last), 512'd0);
    chk({tag, "_hdata"}, host_data, 512'd0);
    chk({tag, "_count"}, 512'(line_count), 512'd0);
    chk({tag, "_ovf"}, 512'(overflow), 512'd0);
    chk({tag, "_done"}, 512'(done), 512'd0);
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    mq.delete();
    m_active   = 1'b0;
    in_valid   = 1'b0;
    in_finish  = 1'b0;
    in_request = 1'b0;
    host_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // rdy_after < 0: random host_ready; else ready once rdy_after lines have been sent.
  task automatic run_batch(input int n, input bit ign, input int rdy_after,
                           input bit fin_last, input bit rnd, input int abort_at);
    int i, guard;
    bit v, fin;
    mq.delete();
    m_cnt = 0; m_ovf = 1'b0; got_trailer = 1'b0; fin = 1'b0;
    in_request = 1'b1; host_ready = 1'b0; in_valid = 1'b0; in_finish = 1'b0;
    cyc();
    chk("permit_up", 512'(in_permit), 512'd1);
    chk("count_clr", 512'(line_count), 512'd0);
    chk("ovf_clr", 512'(overflow), 512'd0);
    m_active = 1'b1;
    i = 0; guard = 0;
    while (i < n && guard < 400) begin
      guard++;
      v   = ign || !stall;
      fin = fin_last && v && (i == n - 1);
      in_valid   = v;
      in_data    = rnd ? rand_line() : 512'(i + 1);
      in_finish  = fin;
      host_ready = (rdy_after < 0) ? 1'($urandom_range(0, 1)) : (i >= rdy_after);
      cyc();
      if (v) i++;
      if (abort_at >= 0 && i == abort_at) begin
        mid_reset();
        return;
      end
      chk("line_count", 512'(line_count), 512'(m_cnt));
      chk("hvalid", 512'(host_valid), 512'(mq.size() != 0));
      if (!fin) chk("stall", 512'(stall), 512'(mq.size() >= 12));
    end
    if (guard >= 400) chk("push_timeout", 512'd0, 512'd1);
    in_valid = 1'b0;
    if (!fin_last) begin
      in_finish = 1'b1;
      cyc();
    end
    chk("permit_down", 512'(in_permit), 512'd0);
    guard = 0;
    while (!got_trailer && guard < 300) begin
      host_ready = (rdy_after < 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      guard++;
    end
    if (!got_trailer) chk("trailer_timeout", 512'd0, 512'd1);
    chk("done", 512'(done), 512'd1);
    chk("overflow", 512'(overflow), 512'(m_ovf));
    chk("final_count", 512'(line_count), 512'(m_cnt));
    chk("hvalid_done", 512'(host_valid), 512'd0);
    chk("lines_left", 512'(mq.size()), 512'd0);
    in_request = 1'b0; in_finish = 1'b0; host_ready = 1'b0; m_active = 1'b0;
    cyc();
    chk("done_clr", 512'(done), 512'd0);
    chk("stall_idle", 512'(stall), 512'd1);
  endtask

  initial begin
    reset = 1'b1; in_request = 1'b0; in_valid = 1'b0; in_finish = 1'b0;
    host_ready = 1'b0; in_data = '0; m_active = 1'b0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_batch(5, 1'b0, 0, 1'b0, 1'b0, -1);    // lines 1..5, host always ready
    chk("single_count", 512'(m_cnt), 512'd5);
    run_batch(12, 1'b0, 99, 1'b0, 1'b1, -1);  // back-pressure to stall
    run_batch(18, 1'b1, 99, 1'b0, 1'b1, -1);  // overflow: two drops
    chk("ovf_model_count", 512'(m_cnt), 512'd16);
    run_batch(19, 1'b1, 16, 1'b0, 1'b1, -1);  // full, then push+pop together
    run_batch(4, 1'b0, 0, 1'b1, 1'b1, -1);    // finish with last line
    run_batch(8, 1'b0, 0, 1'b0, 1'b1, 3);     // reset after 3 lines
    run_batch(2, 1'b0, 0, 1'b0, 1'b1, -1);
    for (int b = 0; b < 4; b++)
      run_batch(int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)), -1,
                1'($urandom_range(0, 1)), 1'b1, -1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/smem_result_writer.md
# smem_result_writer

Downstream consumer of the SMEM curr/mem output stage. Grants the output permit, accepts 512-bit result lines (read headers and packed mem pairs) into a first-word-fall-through FIFO, back-pressures the producer through its stall input, and streams lines to the host write channel over a valid/ready handshake. After the producer signals finish, it drains the FIFO and appends one trailer line carrying the total line count.

## Interface

- `FIFO_DEPTH`, 16: result FIFO entries; power of two, ≥ 8.
- `STALL_MARGIN`, 4: free entries reserved for lines already in flight when stall asserts.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_request` input 1: producer has results ready (level).
- `in_permit` output 1: grant to producer; producer emits lines only while high.
- `in_data` input 512: result line.
- `in_valid` input 1: `in_data` valid this cycle.
- `in_finish` input 1: producer done; sticky high once set.
- `stall` output 1: back-pressure to producer.
- `host_data` output 512: line to host.
- `host_valid` output 1: `host_data` valid.
- `host_ready` input 1: host accepts the beat when `host_valid` && `host_ready`.
- `host_last` output 1: marks the trailer beat.
- `line_count` output 32: lines accepted from the producer this batch.
- `overflow` output 1: sticky error flag; a line arrived while the FIFO was full.
- `done` output 1: trailer accepted by host; held until batch end.

## Operation

- FSM states: IDLE, GRANT, DRAIN, TRAILER, DONE. Reset state is IDLE.
- IDLE: when `in_request`=1, clear `line_count` and `overflow`, then go to GRANT.
- GRANT: `in_permit`=1 (registered). Push `in_data` on every `in_valid`. When `in_finish`=1 is sampled, go to DRAIN. `in_valid` and `in_finish` may be high in the same cycle; the line is pushed.
- DRAIN: `in_permit`=0. Any `in_valid` is still pushed. Go to TRAILER when the FIFO is empty and `in_valid`=0.
- TRAILER: `host_valid`=1, `host_last`=1. `host_data[31:0]`=`line_count`, `[63:32]`=32'hFFFF_FFFF, all other bits 0. On the handshake, go to DONE.
- DONE: `done`=1. Return to IDLE only when `in_request`=0.
- Push rule: a push is accepted if count < `FIFO_DEPTH`, or if a pop happens in the same cycle. Otherwise the line is dropped, `overflow` is set, and `line_count` does not increment.
- `line_count` increments once per accepted push and saturates at 32'hFFFF_FFFF.
- FIFO host side (GRANT/DRAIN): `host_valid` = !empty. `host_data` = head entry. Pop occurs on `host_valid` && `host_ready`. `host_last`=0.
- `stall` = (count ≥ `FIFO_DEPTH` − `STALL_MARGIN`). It is registered from the post-update count and is also forced to 1 in IDLE, TRAILER and DONE.
- Read/write pointers wrap modulo `FIFO_DEPTH`. Count width is log2(`FIFO_DEPTH`)+1.

## Timing

- Reset values: `in_permit`=0, `stall`=1, `host_valid`=0, `host_last`=0, `host_data`=0, `line_count`=0, `overflow`=0, `done`=0. FIFO pointers and count = 0.
- `reset` asserted mid-batch clears all state immediately and discards FIFO contents. Outputs take their reset values asynchronously.
- `in_permit` rises 1 cycle after `in_request` is sampled high in IDLE, and falls 1 cycle after `in_finish` is sampled.
- Push to `host_valid`: a line pushed at edge N appears on `host_data` with `host_valid`=1 after edge N (visible in cycle N+1).
- `stall` reflects the count after edge N's push/pop, starting in cycle N+1. The producer reacts one cycle late, so up to `STALL_MARGIN` further lines must still fit.
- Sustained throughput with `host_ready`=1: one line per cycle.
- `host_data` and `host_valid` hold stable while `host_valid`=1 and `host_ready`=0.
- `done` rises the cycle after the trailer handshake.

## Test plan

- **Single batch, host always ready:** request, then 5 lines with values 1..5, then finish. Required response: host sees 1..5 in order, then the trailer with `[31:0]`=5, `[63:32]`=FFFF_FFFF and `host_last`=1. `done`=1 and `overflow`=0.
- **Back-pressure:** `host_ready`=0 while 12 lines are pushed, depth 16, margin 4. Required response: `stall` goes to 1 in the cycle after the 12th push. After `host_ready` is released, all 12 lines arrive intact in order.
- **Overflow:** ignore `stall` and push 18 lines with `host_ready`=0. Required response: lines 17 and 18 are dropped, `overflow`=1, and the trailer count = 16.
- **Simultaneous push/pop when full:** FIFO full, then `in_valid` and `host_ready` both 1 for 3 cycles. Required response: no drops, count stays at 16, `overflow`=0.
- **Finish coincident with last line:** `in_valid`=1 and `in_finish`=1 in the same cycle. Required response: that line is delivered before the trailer, and the trailer count includes it.
- **Mid-batch reset:** assert `reset` after 3 of 8 lines. Required response: all outputs reach reset values immediately. The next batch of 2 lines yields trailer count = 2.
